// File: rtl/dot_product_pkg.sv
// Shared sizing helpers for the dot-product engine.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package dot_product_pkg;

    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic int sum_width(input int a_w, input int b_w, input int dim);
        return a_w + b_w + CLOG2(dim);
    endfunction

    // Register stages from input to result: S0, S1, tree levels, ACC.
    function automatic int pipe_depth(input int dim);
        return 3 + CLOG2(dim);
    endfunction

endpackage

// File: rtl/dot_product_stream_adder_tree.sv
// Registered binary adder tree reducing N lanes to one sum, padding to a power of two with zeros.
// Latency: CLOG2(N) cycles (combinational pass-through when N = 1).
// Backpressure: every level holds while en is low.
module pipelined_adder_tree
    import dot_product_pkg::*;
#(
    parameter int N        = 8,
    parameter int IN_WIDTH = 64,
    parameter int SIGNED   = 0
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [N*IN_WIDTH-1:0]         u,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [IN_WIDTH+CLOG2(N)-1:0]  sum
);
    localparam int L  = CLOG2(N);
    localparam int NP = 1 << L;
    localparam int SW = IN_WIDTH + L;

    // Heap layout: node k has children 2k+1 and 2k+2; leaves occupy the last NP slots.
    // Leaves are extended to the full output width once, so no level can overflow.
    logic [SW-1:0] node [2*NP-1];

    for (genvar j = 0; j < NP; j++) begin : g_leaf
        if (j < N) begin : g_lane
            if (SIGNED != 0) begin : g_sext
                assign node[NP-1+j] = SW'($signed(u[j*IN_WIDTH +: IN_WIDTH]));
            end else begin : g_zext
                assign node[NP-1+j] = SW'(u[j*IN_WIDTH +: IN_WIDTH]);
            end
        end else begin : g_pad
            assign node[NP-1+j] = '0;
        end
    end

    if (L == 0) begin : g_bypass
        assign out_valid = in_valid;
        assign out_last  = in_last;
    end else begin : g_tree
        logic [SW-1:0] inner [NP-1];
        logic [L-1:0]  vld_sr;
        logic [L-1:0]  last_sr;

        for (genvar k = 0; k < NP-1; k++) begin : g_node
            assign node[k] = inner[k];
        end

        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                vld_sr  <= '0;
                last_sr <= '0;
                for (int k = 0; k < NP-1; k++) inner[k] <= '0;
            end else if (en) begin
                vld_sr  <= L'({vld_sr, in_valid});
                last_sr <= L'({last_sr, in_last});
                for (int k = 0; k < NP-1; k++) inner[k] <= node[2*k+1] + node[2*k+2];
            end
        end

        assign out_valid = vld_sr[L-1];
        assign out_last  = last_sr[L-1];
    end

    assign sum = node[0];

endmodule

// File: rtl/dot_product_stream.sv
// Streaming dot product: lane-wise multiply, adder-tree reduce, accumulate to in_last.
// Latency: 3+CLOG2(DIM) cycles from accepted last beat to out_valid; 1 beat/cycle.
// Backpressure: whole pipeline stalls while out_valid && !out_ready. Option: DOT_PRODUCT_SATURATE_EN.
module dot_product_stream
    import dot_product_pkg::*;
#(
    parameter int DIM          = 8,
    parameter int A_DATA_WIDTH = 32,
    parameter int B_DATA_WIDTH = 32,
    parameter int ACC_WIDTH    = 80,
    parameter int SIGNED       = 0
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [DIM*A_DATA_WIDTH-1:0]   A,
    input  logic [DIM*B_DATA_WIDTH-1:0]   B,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          DotProduct,
    output logic                          ovf
);
    localparam int PW = prod_width(A_DATA_WIDTH, B_DATA_WIDTH);
    localparam int SW = sum_width(A_DATA_WIDTH, B_DATA_WIDTH, DIM);

    logic                        en;
    logic                        s0_vld, s0_last, s1_vld, s1_last, t_vld, t_last;
    logic [DIM*A_DATA_WIDTH-1:0] s0_a;
    logic [DIM*B_DATA_WIDTH-1:0] s0_b;
    logic [DIM*PW-1:0]           prod_d, s1_prod;
    logic [SW-1:0]               t_sum;
    logic [ACC_WIDTH-1:0]        sum_ext, acc, acc_nxt;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s0_vld  <= 1'b0;
            s0_last <= 1'b0;
            s0_a    <= '0;
            s0_b    <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_prod <= '0;
        end else if (en) begin
            s0_vld  <= in_valid;
            s0_last <= in_last;
            s0_a    <= A;
            s0_b    <= B;
            s1_vld  <= s0_vld;
            s1_last <= s0_last;
            s1_prod <= prod_d;
        end
    end

    // The low PW bits of a product do not depend on signedness once operands are extended.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic [PW-1:0] a_x, b_x;
        if (SIGNED != 0) begin : g_sext
            assign a_x = PW'($signed(s0_a[i*A_DATA_WIDTH +: A_DATA_WIDTH]));
            assign b_x = PW'($signed(s0_b[i*B_DATA_WIDTH +: B_DATA_WIDTH]));
        end else begin : g_zext
            assign a_x = PW'(s0_a[i*A_DATA_WIDTH +: A_DATA_WIDTH]);
            assign b_x = PW'(s0_b[i*B_DATA_WIDTH +: B_DATA_WIDTH]);
        end
        assign prod_d[i*PW +: PW] = a_x * b_x;
    end

    pipelined_adder_tree #(
        .N        (DIM),
        .IN_WIDTH (PW),
        .SIGNED   (SIGNED)
    ) u_tree (
        .Clock     (Clock),
        .Reset     (Reset),
        .en        (en),
        .in_valid  (s1_vld),
        .in_last   (s1_last),
        .u         (s1_prod),
        .out_valid (t_vld),
        .out_last  (t_last),
        .sum       (t_sum)
    );

    if (SIGNED != 0) begin : g_sum_sext
        assign sum_ext = ACC_WIDTH'($signed(t_sum));
    end else begin : g_sum_zext
        assign sum_ext = ACC_WIDTH'(t_sum);
    end

`ifdef DOT_PRODUCT_SATURATE_EN
    logic [ACC_WIDTH-1:0] acc_sum;
    logic                 clamp;
    logic                 ovf_acc;

    always_comb begin
        acc_sum = acc + sum_ext;
        acc_nxt = acc_sum;
        clamp   = 1'b0;
        if (SIGNED != 0) begin
            // Overflow only when both addends share a sign the result lacks.
            if ((acc[ACC_WIDTH-1] == sum_ext[ACC_WIDTH-1]) && (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1])) begin
                clamp   = 1'b1;
                acc_nxt = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (acc_sum < acc) begin
            clamp   = 1'b1;
            acc_nxt = '1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ovf_acc <= 1'b0;
            ovf     <= 1'b0;
        end else if (en && t_vld) begin
            if (t_last) begin
                ovf     <= ovf_acc | clamp;
                ovf_acc <= 1'b0;
            end else begin
                ovf_acc <= ovf_acc | clamp;
            end
        end
    end
`else
    assign acc_nxt = acc + sum_ext;
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc        <= '0;
            out_valid  <= 1'b0;
            DotProduct <= '0;
        end else if (en) begin
            out_valid <= t_vld && t_last;
            if (t_vld) begin
                if (t_last) begin
                    DotProduct <= acc_nxt;
                    acc        <= '0;
                end else begin
                    acc <= acc_nxt;
                end
            end
        end
    end

endmodule
